// File: rtl/inst_queue.sv
// Circular instruction FIFO between fetch and decode. Head entry is presented
// combinationally from storage; occupancy count disambiguates full from empty.
module inst_queue #(
    parameter int ADDR_WIDTH = 32,
    parameter int INST_WIDTH = 32,
    parameter int DEPTH      = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_flush_n,
    input  logic                         i_fetch_e_n,
    input  logic [INST_WIDTH-1:0]        i_fetch_inst,
    input  logic [ADDR_WIDTH-1:0]        i_fetch_pc,
    output logic                         o_fetch_full,
    input  logic                         i_dec_stall,
    output logic                         o_inst_e_n,
    output logic [INST_WIDTH-1:0]        o_inst,
    output logic [ADDR_WIDTH-1:0]        o_inst_pc,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_overflow
);

    localparam int PTR = $clog2(DEPTH);
    localparam int CNT = $clog2(DEPTH + 1);
    localparam logic [CNT-1:0] FULL_COUNT = CNT'(DEPTH);

    logic [INST_WIDTH-1:0] r_inst_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_pc_mem   [DEPTH];
    logic [PTR-1:0]        r_rd_ptr;
    logic [PTR-1:0]        r_wr_ptr;
    logic [CNT-1:0]        r_count;
    logic                  r_overflow;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == FULL_COUNT);
    assign w_pop   = !w_empty && !i_dec_stall;
    assign w_push  = !i_fetch_e_n && (!w_full || w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (!i_flush_n) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
            if (!i_fetch_e_n && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Storage is deliberately left uncleared; validity comes from r_count.
    always_ff @(posedge clk) begin
        if (i_flush_n && w_push) begin
            r_inst_mem[r_wr_ptr] <= i_fetch_inst;
            r_pc_mem[r_wr_ptr]   <= i_fetch_pc;
        end
    end

    assign o_inst_e_n   = w_empty;
    assign o_fetch_full = w_full;
    assign o_count      = r_count;
    assign o_overflow   = r_overflow;
    assign o_inst       = w_empty ? '0 : r_inst_mem[r_rd_ptr];
    assign o_inst_pc    = w_empty ? '0 : r_pc_mem[r_rd_ptr];

    a_count_range: assert property (@(posedge clk) disable iff (!rst_n)
        r_count <= FULL_COUNT);
    a_full_valid: assert property (@(posedge clk) disable iff (!rst_n)
        !(o_fetch_full && o_inst_e_n));

endmodule

// File: tb/tb_inst_queue.sv
// Self-checking bench for inst_queue: vector table for fill/boundary/drain,
// plus hand sequences for wrap-around ordering, flush and async reset.
module tb_inst_queue;

    localparam logic [31:0] RV_ADD = 32'h00B50533;

    logic        clk;
    logic        rst_n;
    logic        flushN;
    logic        fetchEN;
    logic [31:0] fetchInst;
    logic [31:0] fetchPc;
    logic        fetchFull;
    logic        decStall;
    logic        instEN;
    logic [31:0] inst;
    logic [31:0] instPc;
    logic [3:0]  count;
    logic        overflow;

    int nChecks = 0;
    int nFails  = 0;

    inst_queue #(.ADDR_WIDTH(32), .INST_WIDTH(32), .DEPTH(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_flush_n    (flushN),
        .i_fetch_e_n  (fetchEN),
        .i_fetch_inst (fetchInst),
        .i_fetch_pc   (fetchPc),
        .o_fetch_full (fetchFull),
        .i_dec_stall  (decStall),
        .o_inst_e_n   (instEN),
        .o_inst       (inst),
        .o_inst_pc    (instPc),
        .o_count      (count),
        .o_overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        flushN;
        logic        fetchEN;
        logic [31:0] inst;
        logic [31:0] pc;
        logic        stall;
        logic        expEN;
        logic [31:0] expInst;
        logic [31:0] expPc;
        logic [3:0]  expCount;
        logic        expFull;
        logic        expOvf;
    } vec_t;

    vec_t vecs[$];

    task automatic addRow(input logic fl, input logic fe, input logic [31:0] in,
                          input logic [31:0] pc, input logic st, input logic eEN,
                          input logic [31:0] eInst, input logic [31:0] ePc,
                          input int eCount, input logic eFull, input logic eOvf);
        vec_t v;
        v.flushN = fl; v.fetchEN = fe; v.inst = in; v.pc = pc; v.stall = st;
        v.expEN = eEN; v.expInst = eInst; v.expPc = ePc;
        v.expCount = 4'(eCount); v.expFull = eFull; v.expOvf = eOvf;
        vecs.push_back(v);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic fl, input logic fe, input logic [31:0] in,
                                 input logic [31:0] pc, input logic st);
        @(negedge clk);
        flushN    = fl;
        fetchEN   = fe;
        fetchInst = in;
        fetchPc   = pc;
        decStall  = st;
    endtask

    task automatic checkAll(input string tag, input logic eEN, input logic [31:0] eInst,
                            input logic [31:0] ePc, input int eCount,
                            input logic eFull, input logic eOvf);
        checkOutput({tag, "_inst_e_n"}, 32'(instEN), 32'(eEN));
        checkOutput({tag, "_inst"}, inst, eInst);
        checkOutput({tag, "_inst_pc"}, instPc, ePc);
        checkOutput({tag, "_count"}, 32'(count), 32'(eCount));
        checkOutput({tag, "_full"}, 32'(fetchFull), 32'(eFull));
        checkOutput({tag, "_overflow"}, 32'(overflow), 32'(eOvf));
    endtask

    initial begin
        logic [31:0] q[$];
        int sent;
        int recv;
        logic popNow;
        logic pushNow;

        rst_n = 1'b0; flushN = 1'b1; fetchEN = 1'b1;
        fetchInst = '0; fetchPc = '0; decStall = 1'b0;
        #12;
        checkAll("reset", 1'b1, 32'h0, 32'h0, 0, 1'b0, 1'b0);
        rst_n = 1'b1;

        // Latency-1 push into empty, then pop back to empty
        addRow(1, 0, RV_ADD, 32'h200, 0,  0, RV_ADD, 32'h200, 1, 0, 0);
        addRow(1, 1, 32'h0, 32'h0, 0,     1, 32'h0, 32'h0, 0, 0, 0);
        addRow(1, 1, 32'h0, 32'h0, 0,     1, 32'h0, 32'h0, 0, 0, 0);
        // Fill under stall; head stays the first entry
        for (int k = 0; k < 8; k++)
            addRow(1, 0, 32'h1000 + k, 32'h100 + 4 * k, 1,
                   0, 32'h1000, 32'h100, k + 1, k == 7, 0);
        // Full with pop: accepted, count stays 8
        addRow(1, 0, 32'hDEADBEEF, 32'h300, 0,  0, 32'h1001, 32'h104, 8, 1, 0);
        // Full without pop: dropped, sticky overflow
        addRow(1, 0, 32'h00000BAD, 32'h304, 1,  0, 32'h1001, 32'h104, 8, 1, 1);
        for (int j = 2; j < 8; j++)
            addRow(1, 1, 32'h0, 32'h0, 0,
                   0, 32'h1000 + j, 32'h100 + 4 * j, 9 - j, 0, 1);
        addRow(1, 1, 32'h0, 32'h0, 0,  0, 32'hDEADBEEF, 32'h300, 1, 0, 1);
        addRow(1, 1, 32'h0, 32'h0, 0,  1, 32'h0, 32'h0, 0, 0, 1);
        addRow(0, 1, 32'h0, 32'h0, 0,  1, 32'h0, 32'h0, 0, 0, 0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].flushN, vecs[i].fetchEN, vecs[i].inst,
                          vecs[i].pc, vecs[i].stall);
            @(posedge clk); #1;
            checkAll($sformatf("vec%0d", i), vecs[i].expEN, vecs[i].expInst,
                     vecs[i].expPc, vecs[i].expCount, vecs[i].expFull, vecs[i].expOvf);
        end

        // Wrap-around ordering with a stall that toggles every 3 cycles
        sent = 0; recv = 0;
        for (int cyc = 0; cyc < 300 && recv < 20; cyc++) begin
            @(negedge clk);
            decStall = ((cyc / 3) % 2) == 1;
            popNow   = (q.size() > 0) && !decStall;
            pushNow  = (sent < 20) && ((q.size() < 8) || popNow);
            fetchEN   = !pushNow;
            fetchPc   = 32'h600 + 4 * sent;
            fetchInst = 32'h6000 + sent;
            flushN    = 1'b1;
            checkOutput("wrap_inst_e_n", 32'(instEN), 32'(q.size() == 0));
            if (q.size() > 0) checkOutput("wrap_pc", instPc, q[0]);
            @(posedge clk);
            if (popNow) begin
                void'(q.pop_front());
                recv++;
            end
            if (pushNow) begin
                q.push_back(32'h600 + 4 * sent);
                sent++;
            end
        end
        checkOutput("wrap_received", 32'(recv), 32'd20);
        applyStimulus(1, 1, 32'h0, 32'h0, 0);
        @(posedge clk); #1;
        checkAll("wrap_end", 1'b1, 32'h0, 32'h0, 0, 1'b0, 1'b0);

        // Flush with push and pop requested in the same cycle
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1, 0, 32'h4000 + k, 32'h400 + 4 * k, 1);
            @(posedge clk);
        end
        #1;
        checkAll("pre_flush", 1'b0, 32'h4000, 32'h400, 4, 1'b0, 1'b0);
        applyStimulus(0, 0, 32'h4444, 32'h444, 0);
        @(posedge clk); #1;
        checkAll("flush", 1'b1, 32'h0, 32'h0, 0, 1'b0, 1'b0);
        applyStimulus(1, 0, 32'h5000, 32'h500, 1);
        @(posedge clk); #1;
        checkAll("post_flush", 1'b0, 32'h5000, 32'h500, 1, 1'b0, 1'b0);

        // Async reset mid-run with five entries held
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1, 0, 32'h7000 + k, 32'h700 + 4 * k, 1);
            @(posedge clk);
        end
        #1;
        checkOutput("pre_reset_count", 32'(count), 32'd5);
        @(negedge clk); fetchEN = 1'b1; #2;
        rst_n = 1'b0;
        #1;
        checkAll("async_reset", 1'b1, 32'h0, 32'h0, 0, 1'b0, 1'b0);
        @(negedge clk); rst_n = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: got running expected finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
